// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern-detect controller.
package seq_det_pkg;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic [CNT_W-1:0] thresh;
  } cfg_t;

  localparam logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(4'b1101);
  localparam logic [LEN_W-1:0] DEF_LEN     = LEN_W'(4);
  localparam logic             DEF_OVERLAP = 1'b1;
  localparam logic [CNT_W-1:0] DEF_THRESH  = CNT_W'(0);

  localparam cfg_t DEF_CFG = '{
    pattern: DEF_PATTERN,
    len:     DEF_LEN,
    overlap: DEF_OVERLAP,
    thresh:  DEF_THRESH
  };

  // Mask selecting the low `len` bits of a candidate window.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      m[i] = (LEN_W'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Mealy match engine: bit history, fill counter and length-masked compare.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match
);

  localparam int unsigned      HIST_W   = PAT_W - 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0]  cand;
  logic [PAT_W-1:0]  mask;

  always_comb begin
    cand   = {hist_q, in};
    mask   = len_mask(len);
    match  = en && (fill_q >= (len - LEN_W'(1))) && ((cand & mask) == (pattern & mask));
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = cand[HIST_W-1:0];
      // Non-overlapping mode forces a full fresh window after each hit.
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Pattern-detect controller: config handshake, IDLE/RUN/HALT sequencing, match counter and irq.
module seq_det_ctrl
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             irq
);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             irq_q, irq_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             core_clr, core_en, match;
  logic             len_ok, cnt_max;

  seq_det_core u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (core_clr),
    .en      (core_en),
    .in      (in),
    .pattern (cfg_q.pattern),
    .len     (cfg_q.len),
    .overlap (cfg_q.overlap),
    .match   (match)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    match_cnt_d = match_cnt_q;
    irq_d       = 1'b0;
    cfg_err_d   = 1'b0;
    core_clr    = 1'b0;
    core_en     = (state_q == RUN) && in_valid;
    len_ok      = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    cnt_max     = &match_cnt_q;

    if (cfg_valid && (state_q == IDLE)) begin
      if (len_ok) begin
        cfg_d = '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap, thresh: cfg_thresh};
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          match_cnt_d = '0;
          core_clr    = 1'b1;
        end
      end
      RUN: begin
        // stop beats start and also suppresses counting of a same-cycle hit.
        if (stop) begin
          state_d  = IDLE;
          core_clr = 1'b1;
        end else if (match && !cnt_max) begin
          match_cnt_d = match_cnt_q + CNT_W'(1);
          if ((cfg_q.thresh != '0) && (match_cnt_d == cfg_q.thresh)) begin
            irq_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (stop) begin
          state_d  = IDLE;
          core_clr = 1'b1;
        end else if (start) begin
          state_d     = RUN;
          match_cnt_d = '0;
          core_clr    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == RUN);
    cfg_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cfg_q       <= DEF_CFG;
      match_cnt_q <= '0;
      irq_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      match_cnt_q <= match_cnt_d;
      irq_q       <= irq_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign out       = match;
  assign match_cnt = match_cnt_q;
  assign busy      = busy_q;
  assign irq       = irq_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: driver queues per-cycle expectations, negedge monitor checks them.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  logic             clk = 1'b0;
  logic             rst, cfg_valid, start, stop, in_valid, in_bit;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_thresh;
  logic             cfg_ready, cfg_err, out_bit, busy, irq;
  logic [CNT_W-1:0] match_cnt;

  localparam logic       X  = 1'bx;
  localparam logic [7:0] XC = 8'hxx;

  typedef struct {
    string      nm;
    logic       eo;
    logic [7:0] ec;
    logic       eb;
    logic       ei;
    logic       ee;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_det_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .cfg_err     (cfg_err),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in          (in_bit),
    .out         (out_bit),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // An X expectation means "don't care" for that field in that cycle.
  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    if (!$isunknown(exp)) begin
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "out",       8'(out_bit),   8'(e.eo));
      chk(e.nm, "match_cnt", match_cnt,     e.ec);
      chk(e.nm, "busy",      8'(busy),      8'(e.eb));
      chk(e.nm, "irq",       8'(irq),       8'(e.ei));
      chk(e.nm, "cfg_err",   8'(cfg_err),   8'(e.ee));
      chk(e.nm, "cfg_ready", 8'(cfg_ready), 8'(e.er));
    end
  end

  task automatic cyc(input string nm, input logic cv, input logic st, input logic sp,
                     input logic iv, input logic b,
                     input logic eo, input logic [7:0] ec, input logic eb,
                     input logic ei, input logic ee, input logic er);
    exp_t e;
    cfg_valid = cv;
    start     = st;
    stop      = sp;
    in_valid  = iv;
    in_bit    = b;
    e.nm = nm; e.eo = eo; e.ec = ec; e.eb = eb; e.ei = ei; e.ee = ee; e.er = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                         input logic o, input logic [CNT_W-1:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_thresh  = t;
  endtask

  // Feed n bits MSB-first in RUN; om marks the bits expected to raise out.
  task automatic run_stream(input string p, input logic [15:0] bits, input logic [15:0] om,
                            input int n, input int c0);
    int c = c0;
    for (int i = n - 1; i >= 0; i--) begin
      cyc($sformatf("%s_bit%0d", p, n - i), 1'b0, 1'b0, 1'b0, 1'b1, bits[i],
          om[i], 8'(c), 1'b1, 1'b0, 1'b0, 1'b0);
      if (om[i]) c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    set_cfg(4'b0000, 3'd0, 1'b0, 8'd0);
    @(posedge clk);
    #1;

    // Defaults after reset, overlapping 1101
    cyc("rst", 0,0,0,0,0, 0,8'd0,0,0,0,1);
    rst = 1'b1;
    cyc("a_start", 0,1,0,0,0, 0,8'd0,0,0,0,1);
    run_stream("a", 16'b1101101, 16'b0001001, 7, 0);
    cyc("a_idle", 0,0,0,0,1, 0,8'd2,1,0,0,0);
    cyc("a_stop", 0,0,1,0,0, 0,8'd2,1,0,0,0);
    cyc("a_held", 0,0,0,0,0, 0,8'd2,0,0,0,1);

    // Non-overlapping, config and start in the same cycle
    set_cfg(4'b1101, 3'd4, 1'b0, 8'd0);
    cyc("b_cfg", 1,1,0,0,0, 0,8'd2,0,0,0,1);
    run_stream("b", 16'b11011011101, 16'b00010000001, 11, 0);
    cyc("b_idle", 0,0,0,0,0, 0,8'd2,1,0,0,0);
    cyc("b_stop", 0,0,1,0,0, 0,8'd2,1,0,0,0);

    // Bad length rejected; cfg in RUN ignored
    rst = 1'b0;
    cyc("c_rst", 0,0,0,0,0, 0,8'd2,0,0,0,1);
    rst = 1'b1;
    set_cfg(4'b0000, 3'd0, 1'b0, 8'd0);
    cyc("c_badlen", 1,0,0,0,0, 0,8'd0,0,0,0,1);
    cyc("c_errpulse", 0,0,0,0,0, 0,8'd0,0,0,1,1);
    cyc("c_start", 0,1,0,0,0, 0,8'd0,0,0,0,1);
    run_stream("c", 16'b1101, 16'b0001, 4, 0);
    set_cfg(4'b0000, 3'd4, 1'b0, 8'd1);
    cyc("c_run_cfg", 1,0,0,0,0, 0,8'd1,1,0,0,0);
    cyc("c_no_err", 0,0,0,0,0, 0,8'd1,1,0,0,0);
    run_stream("c2", 16'b101, 16'b001, 3, 1);
    cyc("c_idle", 0,0,0,0,0, 0,8'd2,1,0,0,0);
    cyc("c_stop", 0,0,1,0,0, 0,8'd2,1,0,0,0);

    // Threshold 3 on 101 -> irq and HALT, then restart
    set_cfg(4'b0101, 3'd3, 1'b1, 8'd3);
    cyc("d_cfg", 1,1,0,0,0, 0,8'd2,0,0,0,1);
    run_stream("d", 16'b1010101, 16'b0010101, 7, 0);
    cyc("d_irq", 0,0,0,1,0, 0,8'd3,0,1,0,0);
    cyc("d_halt1", 0,0,0,1,1, 0,8'd3,0,0,0,0);
    cyc("d_halt2", 0,0,0,1,1, 0,8'd3,0,0,0,0);
    cyc("d_restart", 0,1,0,0,0, 0,8'd3,0,0,0,0);
    cyc("d_run", 0,0,0,0,0, 0,8'd0,1,0,0,0);
    cyc("d_stop", 0,0,1,0,0, 0,8'd0,1,0,0,0);

    // in_valid gaps mid-pattern, then start+stop collision
    set_cfg(4'b1101, 3'd4, 1'b1, 8'd0);
    cyc("e_cfg", 1,1,0,0,0, 0,8'd0,0,0,0,1);
    cyc("e_b1", 0,0,0,1,1, 0,8'd0,1,0,0,0);
    cyc("e_b2", 0,0,0,1,1, 0,8'd0,1,0,0,0);
    for (int g = 0; g < 3; g++) begin
      cyc($sformatf("e_gap%0d", g), 0,0,0,0,1, 0,8'd0,1,0,0,0);
    end
    cyc("e_b3", 0,0,0,1,0, 0,8'd0,1,0,0,0);
    cyc("e_b4", 0,0,0,1,1, 1,8'd0,1,0,0,0);
    cyc("e_both", 0,1,1,0,0, 0,8'd1,1,0,0,0);
    cyc("e_idle", 0,0,0,0,0, 0,8'd1,0,0,0,1);

    // Reset mid-run restores defaults
    set_cfg(4'b1100, 3'd4, 1'b0, 8'd0);
    cyc("f_cfg", 1,1,0,0,0, 0,8'd1,0,0,0,1);
    run_stream("f", 16'b110, 16'b000, 3, 0);
    rst = 1'b0;
    cyc("f_rst", 0,0,0,1,1, 0,8'd0,1,0,0,0);
    rst = 1'b1;
    cyc("f_after", 0,0,0,1,1, 0,8'd0,0,0,0,1);
    cyc("f_start", 0,1,0,0,0, 0,8'd0,0,0,0,1);
    run_stream("f2", 16'b1101, 16'b0001, 4, 0);
    cyc("f_idle", 0,0,0,0,0, 0,8'd1,1,0,0,0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detect controller built around a shared Mealy-style match engine. Supports:
- runtime configuration of pattern, length, overlap mode and match threshold through a valid/ready handshake;
- sequencing of the detector through idle/run/halt states;
- match counting, with an interrupt pulse when the threshold is reached.

Power-on configuration reproduces the team's standard overlapping 1101 detector, so it drops into existing serial-stream checkers.

Parameters:
- PAT_W, 4, maximum pattern length in bits.
- CNT_W, 8, match counter width.
- LEN_W, $clog2(PAT_W)+1, width of the length field (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (sampled on clk; 0 = reset).
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is matched first, bit 0 last.
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_thresh  in  CNT_W  match count that triggers irq; 0 = disabled.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- start  in  1  begin or restart detection.
- stop  in  1  abort detection.
- in_valid  in  1  serial bit qualifier.
- in  in  1  serial data bit.
- out  out  1  Mealy match output (combinational).
- match_cnt  out  CNT_W  saturating match count.
- busy  out  1  high in RUN.
- irq  out  1  one-cycle pulse on threshold reach.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State = IDLE; history and fill cleared; match_cnt=0; irq=0; cfg_err=0.
  - Configuration = pattern 4'b1101, len 4, overlap 1, thresh 0.
- States are IDLE, RUN and HALT. Encodings live in the package.
- cfg_ready = (state==IDLE). A handshake with 1 <= cfg_len <= PAT_W latches all cfg_* fields at that edge.
- An illegal cfg_len pulses cfg_err the next cycle and leaves the configuration unchanged.
- IDLE -> RUN on start:
  - The start edge clears match_cnt, history and fill.
  - If cfg handshake and start occur in the same cycle, the new configuration is used.
- RUN -> IDLE on stop. History is cleared and match_cnt is held. If start and stop are both high, stop wins.
- HALT:
  - out=0 and inputs are ignored.
  - start -> RUN, clearing the count.
  - stop -> IDLE.
- Detection in RUN:
  - Keep an (PAT_W-1)-bit history shift register and a fill counter saturating at PAT_W-1.
  - The candidate is {history, in}; only its low len bits are compared.
  - out = busy & in_valid & (fill >= len-1) & (candidate[len-1:0] == pattern[len-1:0]).
- On an in_valid edge:
  - Shift in; fill++ (saturating).
  - On a match with overlap=0, clear fill to 0.
  - When in_valid=0, history, fill and match_cnt all hold and out=0.
- match_cnt:
  - Increments on each out=1 edge and saturates at 2^CNT_W-1.
  - If thresh!=0 and the incremented value == thresh: irq=1 for exactly one cycle (registered), and the state goes to HALT at the same edge.
- Latency: out is zero-latency (same cycle as the bit); match_cnt and irq update one edge later.
- Reset mid-RUN/HALT returns to full reset values and the default configuration.

Decomposition:
- Package seq_det_pkg holds:
  - state enum IDLE/RUN/HALT;
  - default constants DEF_PATTERN=4'b1101, DEF_LEN=4, DEF_OVERLAP=1, DEF_THRESH=0.
- One natural sub-module, seq_det_core:
  - contains the history register, fill counter and masked compare;
  - has ports clk, rst, clr, en, in, pattern, len, overlap, match.
- Controller FSM, configuration registers and counter stay in seq_det_ctrl.

Test Plan:
- Defaults after reset. start, then in_valid=1 with stream 1,1,0,1,1,0,1 -> out=1 on bits 4 and 7 only; match_cnt=2; busy=1.
- Non-overlap. Configure overlap=0 (pattern 1101, len 4), start, same stream 1101101 -> single out on bit 4; match_cnt=1. Then extend with 1101 -> match_cnt=2.
- Bad config. cfg_len=0 in IDLE -> cfg_err pulses once; the default 1101 still detected afterwards. cfg_valid while in RUN -> cfg_ready=0 and nothing latched.
- Threshold. Configure thresh=3, pattern 3'b101, len 3, overlap 1, stream 10101010 -> out on bits 3, 5 and 7; irq pulses the cycle after bit 7; state HALT; out stays 0 on further 1s. Then start -> RUN with match_cnt=0.
- Gaps and collisions:
  - in_valid deasserted for 3 cycles mid-pattern 11_01 -> match still on the final bit.
  - start+stop together in RUN -> IDLE.
- Reset mid-run: rst=0 after 110 in RUN -> next cycle IDLE, match_cnt=0, defaults restored, out=0.
